// File: rtl/flac_pkg.sv
// Shared definitions for the FLAC residual sequencer: FSM states, coding methods,
// escape codes and header field widths.
package flac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_METHOD,
    ST_ORDER,
    ST_PARAM,
    ST_UNARY,
    ST_LSB,
    ST_ESCW,
    ST_RAW,
    ST_ZERO,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] METHOD_RICE4 = 2'b00;
  localparam logic [1:0] METHOD_RICE5 = 2'b01;

  localparam logic [4:0] ESC4 = 5'h0F;
  localparam logic [4:0] ESC5 = 5'h1F;

  localparam int METHOD_W = 2;
  localparam int ORDER_W  = 4;
  localparam int PARAM4_W = 4;
  localparam int PARAM5_W = 5;
  localparam int ESCW_W   = 5;

endpackage

// File: rtl/partition_counter.sv
// Tracks remaining samples in the current partition and the partition index.
// Partition 0 loses the predictor warm-up samples; counts change only on explicit strobes.
module partition_counter
  import flac_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_i,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic               next_i,
  input  logic [ORDER_W-1:0] order_i,
  input  logic [15:0]        block_size_i,
  input  logic [3:0]         pred_order_i,
  output logic               part_empty_o,
  output logic               last_sample_o,
  output logic               last_part_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] part_len;
  logic [15:0] load_val;

  assign part_len      = block_size_i >> order_i;
  assign load_val      = (idx_q == 16'd0) ? (part_len - {12'd0, pred_order_i}) : part_len;
  assign part_empty_o  = (load_val == 16'd0);
  assign last_sample_o = (cnt_q == 16'd1);
  assign last_part_o   = (idx_q == ((16'd1 << order_i) - 16'd1));

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (init_i) begin
      cnt_d = 16'd0;
      idx_d = 16'd0;
    end else begin
      if (load_i) cnt_d = load_val;
      else if (dec_i) cnt_d = cnt_q - 16'd1;
      if (next_i) idx_d = idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
      idx_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/residual_partition_sequencer.sv
// Parses one FLAC residual section bit-serially and emits (MSB, LSB, param) per residual.
// Results are registered one cycle after their last bit; iEnable=0 stalls all bit-consuming states.
module residual_partition_sequencer
  import flac_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] MAX_MSB = 16'hFFFF
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iEnable,
  input  logic              iData,
  input  logic              iStart,
  input  logic [15:0]       iBlockSize,
  input  logic [3:0]        iPredictorOrder,
  output logic [DATA_W-1:0] oMSB,
  output logic [DATA_W-1:0] oLSB,
  output logic [4:0]        oRiceParam,
  output logic              oEscape,
  output logic              oValid,
  output logic              oBlockDone,
  output logic              oError
);

  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic              rice5_q, rice5_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [4:0]        param_q, param_d;
  logic              esc_q, esc_d;
  logic [4:0]        escw_q, escw_d;
  logic [DATA_W-1:0] msb_q, msb_d;
  logic [DATA_W-1:0] omsb_q, omsb_d;
  logic [DATA_W-1:0] olsb_q, olsb_d;
  logic [4:0]        oprm_q, oprm_d;
  logic              oesc_q, oesc_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cnt_init, cnt_load, cnt_dec, cnt_next;
  logic              part_empty, last_sample, last_part;

  logic [DATA_W-1:0] v_next;
  logic [ORDER_W-1:0] ord_nxt;
  logic              ord_err;
  logic              sign_bit;
  logic [DATA_W-1:0] raw_ext;
  logic [4:0]        param_w;
  logic              emit, go_err;
  logic [DATA_W-1:0] e_msb, e_lsb;
  logic [4:0]        e_prm;
  logic              e_esc;

  assign v_next  = {sr_q[DATA_W-2:0], iData};
  assign ord_nxt = v_next[ORDER_W-1:0];
  assign ord_err = (|(iBlockSize & ((16'd1 << ord_nxt) - 16'd1))) ||
                   ((iBlockSize >> ord_nxt) < {12'd0, iPredictorOrder});
  // Widths at or beyond DATA_W shift the mask out entirely, so no extension happens there.
  assign sign_bit = |(v_next & (ONE << (escw_q - 5'd1)));
  assign raw_ext  = sign_bit ? (v_next | (ONES << escw_q)) : v_next;
  assign param_w  = rice5_q ? 5'(PARAM5_W) : 5'(PARAM4_W);

  partition_counter u_part_cnt (
    .clk_i         (iClock),
    .rst_ni        (iReset_n),
    .init_i        (cnt_init),
    .load_i        (cnt_load),
    .dec_i         (cnt_dec),
    .next_i        (cnt_next),
    .order_i       (order_q),
    .block_size_i  (iBlockSize),
    .pred_order_i  (iPredictorOrder),
    .part_empty_o  (part_empty),
    .last_sample_o (last_sample),
    .last_part_o   (last_part)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    rice5_d  = rice5_q;
    order_d  = order_q;
    param_d  = param_q;
    esc_d    = esc_q;
    escw_d   = escw_q;
    msb_d    = msb_q;
    omsb_d   = omsb_q;
    olsb_d   = olsb_q;
    oprm_d   = oprm_q;
    oesc_d   = oesc_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_init = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_next = 1'b0;
    emit     = 1'b0;
    go_err   = 1'b0;
    e_msb    = '0;
    e_lsb    = '0;
    e_prm    = 5'd0;
    e_esc    = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (iStart) begin
          state_d  = ST_METHOD;
          sr_d     = '0;
          bitcnt_d = 5'(METHOD_W);
          err_d    = 1'b0;
        end
      end
      ST_METHOD: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          if (v_next[1:0] == METHOD_RICE4 || v_next[1:0] == METHOD_RICE5) begin
            rice5_d  = (v_next[1:0] == METHOD_RICE5);
            state_d  = ST_ORDER;
            sr_d     = '0;
            bitcnt_d = 5'(ORDER_W);
          end else begin
            go_err = 1'b1;
          end
        end
      end
      ST_ORDER: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          if (ord_err) begin
            go_err = 1'b1;
          end else begin
            order_d  = ord_nxt;
            cnt_init = 1'b1;
            state_d  = ST_PARAM;
            sr_d     = '0;
            bitcnt_d = param_w;
          end
        end
      end
      ST_PARAM: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          param_d  = v_next[4:0];
          esc_d    = rice5_q ? (v_next[4:0] == ESC5) : (v_next[4:0] == ESC4);
          cnt_load = 1'b1;
          sr_d     = '0;
          msb_d    = '0;
          if (part_empty) begin
            // A warm-up-only partition 0 carries a parameter but no residuals.
            if (last_part) begin
              state_d = ST_DONE;
            end else begin
              cnt_next = 1'b1;
              bitcnt_d = param_w;
            end
          end else if (esc_d) begin
            state_d  = ST_ESCW;
            bitcnt_d = 5'(ESCW_W);
          end else begin
            state_d = ST_UNARY;
          end
        end
      end
      ST_UNARY: if (iEnable) begin
        if (!iData) begin
          if (msb_q == MAX_MSB - ONE) go_err = 1'b1;
          else msb_d = msb_q + ONE;
        end else if (param_q == 5'd0) begin
          emit  = 1'b1;
          e_msb = msb_q;
        end else begin
          state_d  = ST_LSB;
          sr_d     = '0;
          bitcnt_d = param_q;
        end
      end
      ST_LSB: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          emit  = 1'b1;
          e_msb = msb_q;
          e_lsb = v_next;
          e_prm = param_q;
        end
      end
      ST_ESCW: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          escw_d   = v_next[4:0];
          sr_d     = '0;
          bitcnt_d = v_next[4:0];
          state_d  = (v_next[4:0] == 5'd0) ? ST_ZERO : ST_RAW;
        end
      end
      ST_RAW: if (iEnable) begin
        sr_d     = v_next;
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          emit  = 1'b1;
          e_lsb = raw_ext;
          e_prm = escw_q;
          e_esc = 1'b1;
        end
      end
      ST_ZERO: if (iEnable) begin
        emit  = 1'b1;
        e_esc = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      omsb_d  = e_msb;
      olsb_d  = e_lsb;
      oprm_d  = e_prm;
      oesc_d  = e_esc;
      cnt_dec = 1'b1;
      sr_d    = '0;
      msb_d   = '0;
      if (last_sample) begin
        if (last_part) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_next = 1'b1;
          state_d  = ST_PARAM;
          bitcnt_d = param_w;
        end
      end else if (esc_q) begin
        state_d  = (escw_q == 5'd0) ? ST_ZERO : ST_RAW;
        bitcnt_d = escw_q;
      end else begin
        state_d = ST_UNARY;
      end
    end

    if (go_err) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      bitcnt_q <= 5'd0;
      rice5_q  <= 1'b0;
      order_q  <= '0;
      param_q  <= 5'd0;
      esc_q    <= 1'b0;
      escw_q   <= 5'd0;
      msb_q    <= '0;
      omsb_q   <= '0;
      olsb_q   <= '0;
      oprm_q   <= 5'd0;
      oesc_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      rice5_q  <= rice5_d;
      order_q  <= order_d;
      param_q  <= param_d;
      esc_q    <= esc_d;
      escw_q   <= escw_d;
      msb_q    <= msb_d;
      omsb_q   <= omsb_d;
      olsb_q   <= olsb_d;
      oprm_q   <= oprm_d;
      oesc_q   <= oesc_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign oMSB       = omsb_q;
  assign oLSB       = olsb_q;
  assign oRiceParam = oprm_q;
  assign oEscape    = oesc_q;
  assign oValid     = valid_q;
  assign oBlockDone = done_q;
  assign oError     = err_q;

endmodule

// File: tb/tb_residual_partition_sequencer.sv
// Directed bench: table of residual sections with hand-computed residual lists, plus an
// async-reset-mid-residual sequence.
module tb_residual_partition_sequencer;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iEnable = 1'b0;
  logic        iData = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iBlockSize = 16'd0;
  logic [3:0]  iPredictorOrder = 4'd0;
  logic [15:0] oMSB, oLSB;
  logic [4:0]  oRiceParam;
  logic        oEscape, oValid, oBlockDone, oError;

  always #5 iClock = ~iClock;

  residual_partition_sequencer dut (
    .iClock          (iClock),
    .iReset_n        (iReset_n),
    .iEnable         (iEnable),
    .iData           (iData),
    .iStart          (iStart),
    .iBlockSize      (iBlockSize),
    .iPredictorOrder (iPredictorOrder),
    .oMSB            (oMSB),
    .oLSB            (oLSB),
    .oRiceParam      (oRiceParam),
    .oEscape         (oEscape),
    .oValid          (oValid),
    .oBlockDone      (oBlockDone),
    .oError          (oError)
  );

  typedef struct {
    logic [15:0] msb;
    logic [15:0] lsb;
    logic [4:0]  prm;
    logic        esc;
    logic        done;
  } res_t;

  typedef struct {
    logic [15:0]  bs;
    logic [3:0]   pred;
    logic [511:0] bits;
    int           nbits;
    int           first;
    int           cnt;
    logic         err;
    int           lat;
    logic         gaps;
  } vec_t;

  vec_t vt[$];
  res_t er[$];
  res_t got[$];

  logic [511:0] cb;
  int cn;
  int vfirst;
  int cyc = 0;
  int done_cyc;
  int nvec = 0;
  int nbad = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  always @(negedge iClock) begin
    if (oValid) begin
      got.push_back('{oMSB, oLSB, oRiceParam, oEscape, oBlockDone});
      if (oBlockDone) done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int w, input logic [31:0] v);
    for (int i = w - 1; i >= 0; i--) begin
      cb[cn] = v[i];
      cn++;
    end
  endtask

  task automatic rice(input int q, input int k, input logic [31:0] r);
    for (int i = 0; i < q; i++) put(1, 32'd0);
    put(1, 32'd1);
    if (k > 0) put(k, r);
  endtask

  task automatic ex(input logic [15:0] m, input logic [15:0] l, input logic [4:0] p,
                    input logic e, input logic d);
    er.push_back('{m, l, p, e, d});
  endtask

  task automatic begin_vec();
    cb = '0;
    cn = 0;
    vfirst = er.size();
  endtask

  task automatic end_vec(input logic [15:0] bs, input logic [3:0] pred, input logic err,
                         input int lat, input logic gaps);
    vt.push_back('{bs, pred, cb, cn, vfirst, er.size() - vfirst, err, lat, gaps});
  endtask

  task automatic build_t1(input logic gaps);
    begin_vec();
    put(2, 0); put(4, 0); put(4, 2);
    for (int i = 0; i < 14; i++) begin
      rice(1, 2, 3);
      ex(16'd1, 16'd3, 5'd2, 1'b0, i == 13);
    end
    end_vec(16'd16, 4'd2, 1'b0, gaps ? 0 : 1, gaps);
  endtask

  task automatic run_vec(input int v);
    int lastc;
    int f;
    lastc = 0;
    got.delete();
    done_cyc = -1;
    iBlockSize      = vt[v].bs;
    iPredictorOrder = vt[v].pred;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    chk($sformatf("v%0d err_after_start", v), 32'(oError), 32'd0);
    for (int i = 0; i < vt[v].nbits; i++) begin
      if (vt[v].gaps) begin
        repeat ($urandom_range(0, 2)) begin
          iEnable = 1'b0;
          iData   = 1'($urandom_range(0, 1));
          @(posedge iClock); #1;
        end
      end
      iEnable = 1'b1;
      iData   = vt[v].bits[i];
      lastc   = cyc;
      @(posedge iClock); #1;
    end
    iEnable = 1'b1;
    iData   = 1'b1;
    repeat (12) @(posedge iClock);
    #1;
    iEnable = 1'b0;
    f = vt[v].first;
    chk($sformatf("v%0d valid_count", v), 32'(got.size()), 32'(vt[v].cnt));
    for (int i = 0; i < vt[v].cnt && i < got.size(); i++) begin
      chk($sformatf("v%0d r%0d msb", v, i),  32'(got[i].msb),  32'(er[f+i].msb));
      chk($sformatf("v%0d r%0d lsb", v, i),  32'(got[i].lsb),  32'(er[f+i].lsb));
      chk($sformatf("v%0d r%0d prm", v, i),  32'(got[i].prm),  32'(er[f+i].prm));
      chk($sformatf("v%0d r%0d esc", v, i),  32'(got[i].esc),  32'(er[f+i].esc));
      chk($sformatf("v%0d r%0d done", v, i), 32'(got[i].done), 32'(er[f+i].done));
    end
    chk($sformatf("v%0d error", v), 32'(oError), 32'(vt[v].err));
    if (vt[v].lat > 0)
      chk($sformatf("v%0d done_latency", v), 32'(done_cyc - lastc), 32'(vt[v].lat));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " msb"},   32'(oMSB), 32'd0);
    chk({tag, " lsb"},   32'(oLSB), 32'd0);
    chk({tag, " prm"},   32'(oRiceParam), 32'd0);
    chk({tag, " esc"},   32'(oEscape), 32'd0);
    chk({tag, " valid"}, 32'(oValid), 32'd0);
    chk({tag, " done"},  32'(oBlockDone), 32'd0);
    chk({tag, " error"}, 32'(oError), 32'd0);
  endtask

  initial begin
    // v0: order 0, param 2, fourteen (1,3) residuals after two warm-up samples
    build_t1(1'b0);

    // v1: four partitions with params 0, 1, 3 and an escaped 4-bit raw partition
    begin_vec();
    put(2, 0); put(4, 2);
    put(4, 0);
    rice(0, 0, 0); ex(16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    rice(1, 0, 0); ex(16'd1, 16'd0, 5'd0, 1'b0, 1'b0);
    rice(2, 0, 0); ex(16'd2, 16'd0, 5'd0, 1'b0, 1'b0);
    rice(3, 0, 0); ex(16'd3, 16'd0, 5'd0, 1'b0, 1'b0);
    put(4, 1);
    rice(0, 1, 1); ex(16'd0, 16'd1, 5'd1, 1'b0, 1'b0);
    rice(2, 1, 0); ex(16'd2, 16'd0, 5'd1, 1'b0, 1'b0);
    rice(1, 1, 1); ex(16'd1, 16'd1, 5'd1, 1'b0, 1'b0);
    rice(0, 1, 0); ex(16'd0, 16'd0, 5'd1, 1'b0, 1'b0);
    put(4, 3);
    rice(1, 3, 5); ex(16'd1, 16'd5, 5'd3, 1'b0, 1'b0);
    rice(0, 3, 7); ex(16'd0, 16'd7, 5'd3, 1'b0, 1'b0);
    rice(0, 3, 0); ex(16'd0, 16'd0, 5'd3, 1'b0, 1'b0);
    rice(3, 3, 2); ex(16'd3, 16'd2, 5'd3, 1'b0, 1'b0);
    put(4, 15); put(5, 4);
    put(4, 4'b1010); ex(16'd0, 16'hFFFA, 5'd4, 1'b1, 1'b0);
    put(4, 4'b0111); ex(16'd0, 16'h0007, 5'd4, 1'b1, 1'b0);
    put(4, 4'b1000); ex(16'd0, 16'hFFF8, 5'd4, 1'b1, 1'b0);
    put(4, 4'b0000); ex(16'd0, 16'h0000, 5'd4, 1'b1, 1'b1);
    end_vec(16'd16, 4'd0, 1'b0, 1, 1'b0);

    // v2: escape width 0 in partition 1 -> four zeros on consecutive cycles, no bits read
    begin_vec();
    put(2, 0); put(4, 1);
    put(4, 1);
    rice(0, 1, 1); ex(16'd0, 16'd1, 5'd1, 1'b0, 1'b0);
    rice(1, 1, 0); ex(16'd1, 16'd0, 5'd1, 1'b0, 1'b0);
    rice(0, 1, 0); ex(16'd0, 16'd0, 5'd1, 1'b0, 1'b0);
    rice(2, 1, 1); ex(16'd2, 16'd1, 5'd1, 1'b0, 1'b0);
    put(4, 15); put(5, 0);
    for (int i = 0; i < 4; i++) ex(16'd0, 16'd0, 5'd0, 1'b1, i == 3);
    end_vec(16'd8, 4'd0, 1'b0, 5, 1'b0);

    // v3: 5-bit params: param 17 (remainder wider than oLSB), then 5'h1F escape width 3
    begin_vec();
    put(2, 1); put(4, 1);
    put(5, 17);
    rice(1, 17, 5);        ex(16'd1, 16'h0005, 5'd17, 1'b0, 1'b0);
    rice(0, 17, 17'h1ABCD); ex(16'd0, 16'hABCD, 5'd17, 1'b0, 1'b0);
    put(5, 31); put(5, 3);
    put(3, 3'b011); ex(16'd0, 16'h0003, 5'd3, 1'b1, 1'b0);
    put(3, 3'b101); ex(16'd0, 16'hFFFD, 5'd3, 1'b1, 1'b1);
    end_vec(16'd4, 4'd0, 1'b0, 1, 1'b0);

    // v4..v6: malformed sections
    begin_vec(); put(2, 2'b10);            end_vec(16'd16, 4'd0, 1'b1, 0, 1'b0);
    begin_vec(); put(2, 0); put(4, 3);     end_vec(16'd12, 4'd0, 1'b1, 0, 1'b0);
    begin_vec(); put(2, 0); put(4, 2);     end_vec(16'd8,  4'd4, 1'b1, 0, 1'b0);

    // v7: restart from ERROR with random enable gaps
    build_t1(1'b1);

    repeat (3) @(posedge iClock);
    #1;
    chk_all_zero("in_reset");
    iReset_n = 1'b1;
    @(posedge iClock); #1;
    chk_all_zero("after_reset");

    for (int v = 0; v < vt.size(); v++) run_vec(v);

    // Async reset while the third residual's remainder is half shifted in
    iBlockSize      = vt[0].bs;
    iPredictorOrder = vt[0].pred;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    for (int i = 0; i < 21; i++) begin
      iEnable = 1'b1;
      iData   = vt[0].bits[i];
      @(posedge iClock); #1;
    end
    iEnable = 1'b0;
    chk("pre_reset lsb", 32'(oLSB), 32'd3);
    chk("pre_reset prm", 32'(oRiceParam), 32'd2);
    #3;
    iReset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge iClock); #4;
    iReset_n = 1'b1;
    @(posedge iClock); #1;
    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
